// File: rtl/ahb_sram_ctrl_if.sv
// ahb_sram_ctrl_if: AHB-Lite slave-port signal bundle with master/slave views.
interface ahb_sram_ctrl_if #(parameter int DATA_W = 32);
  logic HSEL;
  logic [31:0] HADDR;
  logic HWRITE;
  logic [1:0] HTRANS;
  logic [2:0] HSIZE;
  logic [2:0] HBURST;
  logic [DATA_W-1:0] HWDATA;
  logic HREADY;
  logic HREADYOUT;
  logic [1:0] HRESP;
  logic [DATA_W-1:0] HRDATA;
  modport master (output HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HWDATA, HREADY,
                  input HREADYOUT, HRESP, HRDATA);
  modport slave (input HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HWDATA, HREADY,
                 output HREADYOUT, HRESP, HRDATA);
endinterface

// File: rtl/ahb_sram_ctrl.sv
// ahb_sram_ctrl: AHB-Lite SRAM slave with sub-word writes, RAW forwarding and two-cycle ERROR.
// Define AHB_SRAM_WAIT_EN to insert WAIT_STATES wait cycles before each legal data phase.
module ahb_sram_ctrl #(
  parameter int DATA_W = 32,
  parameter int unsigned MEM_DEPTH = 32'h3000,
  parameter int DEC_W = 16,
  parameter int WAIT_STATES = 1
) (
  input logic HCLK,
  input logic HRESETn,
  ahb_sram_ctrl_if.slave bus
);
  localparam int NB = DATA_W / 8;
  localparam int B = $clog2(NB);
  localparam int IW = DEC_W - B;
  localparam logic [2:0] IDLE = 3'd0, DATA = 3'd1, ERR1 = 3'd2, ERR2 = 3'd3;
  if ((DATA_W != 32 && DATA_W != 64) || WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad
    $error("ahb_sram_ctrl: unsupported parameters");
  end
  logic [2:0] state, state_d;
  logic [IW-1:0] idx_a, idx_q, rd_idx;
  logic [B-1:0] off_q;
  logic [2:0] size_q;
  logic wr_q, ready, acc, legal, commit, rd_go;
  logic [7:0] amask;
  logic [NB-1:0] mask;
  logic [NB-1:0][7:0] mem [MEM_DEPTH];
  logic [NB-1:0][7:0] rd_word, rdata_q;
  logic unused;
  assign unused = ^{bus.HBURST, bus.HTRANS[0], bus.HADDR[31:DEC_W]};
  assign acc = ready & bus.HSEL & bus.HTRANS[1] & bus.HREADY;
  assign idx_a = bus.HADDR[DEC_W-1:B];
  assign amask = (8'd1 << bus.HSIZE) - 8'd1;
  assign legal = 32'(idx_a) < MEM_DEPTH && bus.HSIZE <= 3'(B) && ~|(bus.HADDR[7:0] & amask);
  assign mask = ((NB'(1) << (4'd1 << size_q)) - NB'(1)) << off_q;
  assign commit = state == DATA && wr_q;
`ifdef AHB_SRAM_WAIT_EN
  localparam logic [2:0] WAIT = 3'd4;
  logic [3:0] cnt;
  logic last;
  assign last = cnt == 4'd1;
  assign ready = state != ERR1 && state != WAIT;
  assign rd_go = WAIT_STATES == 0 ? acc & legal & ~bus.HWRITE : state == WAIT && last && !wr_q;
  assign rd_idx = WAIT_STATES == 0 ? idx_a : idx_q;
  assign state_d = acc ? (!legal ? ERR1 : WAIT_STATES == 0 ? DATA : WAIT) :
                   state == ERR1 ? ERR2 :
                   state == WAIT ? (last ? DATA : WAIT) : IDLE;
  always_ff @(posedge HCLK)
    if (!HRESETn) cnt <= '0;
    else if (acc) cnt <= 4'(WAIT_STATES);
    else if (state == WAIT) cnt <= cnt - 4'd1;
`else
  assign ready = state != ERR1;
  assign rd_go = acc & legal & ~bus.HWRITE;
  assign rd_idx = idx_a;
  assign state_d = acc ? (legal ? DATA : ERR1) : state == ERR1 ? ERR2 : IDLE;
`endif
  // a read sampled on the edge a write commits to the same word sees the new lanes
  always_comb begin
    rd_word = mem[rd_idx];
    for (int i = 0; i < NB; i++)
      if (commit && mask[i] && rd_idx == idx_q) rd_word[i] = bus.HWDATA[8*i +: 8];
  end
  always_ff @(posedge HCLK)
    for (int i = 0; i < NB; i++)
      if (HRESETn && commit && mask[i]) mem[idx_q][i] <= bus.HWDATA[8*i +: 8];
  always_ff @(posedge HCLK)
    if (!HRESETn) begin
      state <= IDLE;
      wr_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_d;
      if (acc) begin
        idx_q <= idx_a;
        off_q <= bus.HADDR[B-1:0];
        size_q <= bus.HSIZE;
        wr_q <= bus.HWRITE & legal;
      end
      if (rd_go) rdata_q <= rd_word;
    end
  assign bus.HREADYOUT = ready;
  assign bus.HRESP = {1'b0, state == ERR1 || state == ERR2};
  assign bus.HRDATA = rdata_q;
endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// tb_ahb_sram_ctrl: directed and random AHB traffic checked against a byte-level memory model.
module tb_ahb_sram_ctrl;
  localparam int WS = 2;
`ifdef AHB_SRAM_WAIT_EN
  localparam int WAITS = WS;
`else
  localparam int WAITS = 0;
`endif
  typedef struct {
    bit act;
    bit wr;
    logic [31:0] addr;
    logic [2:0] size;
    logic [31:0] wdata;
    bit chk;
    logic [31:0] want;
  } op_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [7:0] mb [256];
  logic [31:0] last_rd = '0;
  op_t q[$];
  ahb_sram_ctrl_if #(.DATA_W(32)) ahb();
  ahb_sram_ctrl #(.DATA_W(32), .MEM_DEPTH(32'h3000), .DEC_W(16), .WAIT_STATES(WS)) dut (
    .HCLK(clk),
    .HRESETn(rstn),
    .bus(ahb)
  );
  always #5 clk = ~clk;
  assign ahb.HREADY = ahb.HREADYOUT;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  function automatic bit ok(input op_t o);
    return o.addr[15:2] < 14'h3000 && o.size <= 3'd2 && o.addr % (32'd1 << o.size) == 0;
  endfunction

  function automatic void put(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                              input logic [31:0] wdata, input bit c = 1'b0, input logic [31:0] want = '0);
    q.push_back('{1'b1, wr, addr, size, wdata, c, want});
  endfunction

  task automatic gen(input int n);
    op_t o;
    int r;
    for (int i = 0; i < n; i++) begin
      o = '{default: 0};
      o.act = $urandom_range(7) != 0;
      o.wr = 1'($urandom_range(1));
      o.size = 3'($urandom_range(2));
      o.addr = {16'($urandom), 8'd0, 8'($urandom)} & ~((32'd1 << o.size) - 32'd1);
      o.wdata = $urandom;
      r = $urandom_range(15);
      if (r == 0) o.addr[15:2] = 14'h3000 + 14'($urandom_range(4095));
      if (r == 1) o.size = 3'd3;
      if (r == 2) o.addr[0] = 1'b1;
      q.push_back(o);
    end
  endtask

  task automatic run();
    op_t ap, dp;
    bit dv = 1'b0;
    int waits = 0;
    int cyc = 0;
    int a;
    logic [31:0] exp_rd;
    dp = '{default: 0};
    while ((q.size() > 0 || dv) && cyc < 5000) begin
      ap = '{default: 0};
      if (q.size() > 0) ap = q[0];
      ahb.HSEL = ap.act;
      ahb.HTRANS = {ap.act, 1'($urandom_range(1))};
      ahb.HWRITE = ap.wr;
      ahb.HADDR = ap.addr;
      ahb.HSIZE = ap.size;
      ahb.HBURST = 3'($urandom_range(7));
      ahb.HWDATA = dv ? dp.wdata : $urandom;
      @(negedge clk);
      if (!dv) begin
        chk("idle_ready", ahb.HREADYOUT, 1);
        chk("idle_resp", ahb.HRESP, 0);
        chk("idle_hold", ahb.HRDATA, last_rd);
      end else if (!ahb.HREADYOUT) begin
        waits++;
        chk("wait_resp", ahb.HRESP, ok(dp) ? 0 : 1);
        chk("wait_hold", ahb.HRDATA, last_rd);
      end else begin
        exp_rd = last_rd;
        a = int'(dp.addr[7:0] & 8'hFC);
        if (ok(dp) && !dp.wr) exp_rd = {mb[a+3], mb[a+2], mb[a+1], mb[a]};
        chk("waits", waits, ok(dp) ? WAITS : 1);
        chk("resp", ahb.HRESP, ok(dp) ? 0 : 1);
        chk("rdata", ahb.HRDATA, exp_rd);
        if (dp.chk) chk("directed", ahb.HRDATA, dp.want);
        last_rd = exp_rd;
        if (ok(dp) && dp.wr)
          for (int k = 0; k < (1 << dp.size); k++) begin
            a = int'(dp.addr[7:0]) + k;
            mb[a] = dp.wdata[8*(a%4) +: 8];
          end
        dv = 1'b0;
        waits = 0;
      end
      if (ahb.HREADYOUT) begin
        if (q.size() > 0) void'(q.pop_front());
        dv = ap.act;
        dp = ap;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("run_done", 32'(q.size() == 0 && !dv), 1);
  endtask

  initial begin
    ahb.HSEL = 1'b0;
    ahb.HTRANS = 2'b00;
    ahb.HWRITE = 1'b0;
    ahb.HADDR = '0;
    ahb.HSIZE = 3'd0;
    ahb.HBURST = 3'd0;
    ahb.HWDATA = '0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst_ready", ahb.HREADYOUT, 1);
    chk("rst_resp", ahb.HRESP, 0);
    chk("rst_rdata", ahb.HRDATA, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 64; i++) put(1'b1, 32'(i * 4), 3'd2, $urandom);
    run();
    put(1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
    put(1'b0, 32'h10, 3'd2, 32'h0, 1'b1, 32'hDEADBEEF);
    put(1'b1, 32'h20, 3'd2, 32'h11223344);
    put(1'b1, 32'h21, 3'd0, 32'h0000AA00);
    put(1'b0, 32'h20, 3'd2, 32'h0, 1'b1, 32'h1122AA44);
    put(1'b1, 32'h40, 3'd2, 32'hCAFEF00D);
    put(1'b0, 32'h40, 3'd2, 32'h0, 1'b1, 32'hCAFEF00D);
    put(1'b0, 32'hC000, 3'd2, 32'h0);
    put(1'b0, 32'h10, 3'd2, 32'h0, 1'b1, 32'hDEADBEEF);
    put(1'b1, 32'h0, 3'd2, 32'h01020304);
    put(1'b1, 32'h3, 3'd1, 32'hFFFFFFFF);
    put(1'b0, 32'h0, 3'd2, 32'h0, 1'b1, 32'h01020304);
    put(1'b1, 32'h80, 3'd2, 32'h13579BDF);
    put(1'b0, 32'h80, 3'd2, 32'h0, 1'b1, 32'h13579BDF);
    run();
    gen(300);
    run();
    put(1'b1, 32'h80, 3'd2, 32'h13579BDF);
    run();
    ahb.HSEL = 1'b1;
    ahb.HTRANS = 2'b10;
    ahb.HWRITE = 1'b1;
    ahb.HADDR = 32'h80;
    ahb.HSIZE = 3'd2;
    @(posedge clk);
    #1;
    ahb.HSEL = 1'b0;
    ahb.HTRANS = 2'b00;
    ahb.HWDATA = 32'hFFFFFFFF;
    rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("midrst_ready", ahb.HREADYOUT, 1);
    chk("midrst_resp", ahb.HRESP, 0);
    chk("midrst_rdata", ahb.HRDATA, 0);
    last_rd = '0;
    @(posedge clk);
    #1;
    put(1'b0, 32'h80, 3'd2, 32'h0, 1'b1, 32'h13579BDF);
    run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
